approx_mult_err_monitor: RTL and testbench

//  Consumer end of the approximate radix-4 Booth multiplier datapath. Takes each
//  (X, Y, P) triple produced at the multiplier output and recomputes the exact

---
 rtl/approx_mult_pkg.sv | 51 +++++
 rtl/err_dist_calc.sv | 92 +++++++++
 rtl/approx_mult_err_monitor.sv | 186 ++++++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier accuracy monitor.
// Holds the monitor FSM encoding, the default error-distance width and the
// saturating accumulate helpers used by the statistics accumulators.
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    localparam int W_DEF = 8;
    localparam int ED_W  = 2 * W_DEF + 1;
    localparam int ACC_W = 64;

    // Unsigned add clamped to width bits; MSB of the result flags saturation.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] inc,
                                               input int               width);
        logic [ACC_W:0] sum_s;
        logic [ACC_W:0] lim_s;
        sum_s = {1'b0, acc} + {1'b0, inc};
        lim_s = (65'd1 << width) - 65'd1;
        if (sum_s > lim_s) begin
            sat_add = {1'b1, lim_s[ACC_W-1:0]};
        end else begin
            sat_add = {1'b0, sum_s[ACC_W-1:0]};
        end
    endfunction

    // Signed add clamped to the two's complement range of width bits.
    function automatic logic [ACC_W:0] sat_add_signed(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [ACC_W-1:0] inc,
                                                      input int                      width);
        logic signed [ACC_W:0] sum_s;
        logic signed [ACC_W:0] max_s;
        logic signed [ACC_W:0] min_s;
        sum_s = $signed({acc[ACC_W-1], acc}) + $signed({inc[ACC_W-1], inc});
        max_s = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_s = -max_s - 65'sd1;
        if (sum_s > max_s) begin
            sat_add_signed = {1'b1, max_s[ACC_W-1:0]};
        end else if (sum_s < min_s) begin
            sat_add_signed = {1'b1, min_s[ACC_W-1:0]};
        end else begin
            sat_add_signed = {1'b0, sum_s[ACC_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/err_dist_calc.sv
// Two-stage error-distance pipeline: stage 1 registers the exact signed
// product and the product under test, stage 2 registers diff = exact - P
// (one bit wider than the product) and its magnitude ED.
// With APPROX_ERR_BIAS_EN defined the signed diff is also exported.
module err_dist_calc
    import approx_mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        y,
    input  logic [2*W-1:0]      p,
    output logic                v1,
    output logic                v2,
`ifdef APPROX_ERR_BIAS_EN
    output logic signed [2*W:0] diff,
`endif
    output logic [2*W:0]        ed
);

    localparam int PW = 2 * W;
    localparam int EW = 2 * W + 1;

    logic [PW-1:0]        prod_s;
    logic [PW-1:0]        exact_r;
    logic [PW-1:0]        p_r;
    logic                 v1_r;
    logic                 v2_r;
    logic signed [EW-1:0] diff_s;
    logic signed [EW-1:0] diff_r;
    logic [EW-1:0]        ed_s;
    logic [EW-1:0]        ed_r;

    // Operands sign-extended to product width: the low 2W bits of the product equal the signed product.
    always_comb begin
        prod_s = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
    end

    // Difference one bit wider than the product so exact - P never wraps; ED is its magnitude.
    always_comb begin
        diff_s = $signed({exact_r[PW-1], exact_r}) - $signed({p_r[PW-1], p_r});
        if (diff_s[EW-1]) begin
            ed_s = $unsigned(-diff_s);
        end else begin
            ed_s = $unsigned(diff_s);
        end
    end

    // Stage 1: capture exact product and P on each accepted triple.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact_r <= {PW{1'b0}};
            p_r     <= {PW{1'b0}};
            v1_r    <= 1'b0;
        end else begin
            v1_r <= load;
            if (load) begin
                exact_r <= prod_s;
                p_r     <= p;
            end
        end
    end

    // Stage 2: register diff and ED for the statistics update one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r <= {EW{1'b0}};
            ed_r   <= {EW{1'b0}};
            v2_r   <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                diff_r <= diff_s;
                ed_r   <= ed_s;
            end
        end
    end

    assign v1 = v1_r;
    assign v2 = v2_r;
    assign ed = ed_r;
`ifdef APPROX_ERR_BIAS_EN
    assign diff = diff_r;
`else
    logic unused_diff_s;
    assign unused_diff_s = ^diff_r;
`endif

endmodule

// File: rtl/approx_mult_err_monitor.sv
// On-chip accuracy monitor for the approximate radix-4 Booth multiplier.
// Accepts N_SAMPLES (X, Y, P) triples per run, recomputes the exact product
// and accumulates error count, max and saturating sum of error distance.
// Optional feature macro: APPROX_ERR_BIAS_EN adds a saturating signed sum of
// (exact - P) on port bias, sharing the sum_ovf flag.
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int N_SAMPLES = 256,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     X,
    input  logic [W-1:0]     Y,
    input  logic [2*W-1:0]   P,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2*W:0]     max_ed,
    output logic [SUM_W-1:0] sum_ed,
`ifdef APPROX_ERR_BIAS_EN
    output logic [SUM_W-1:0] bias,
`endif
    output logic             sum_ovf
);

    localparam int EW = (W == W_DEF) ? ED_W : 2 * W + 1;

    mon_state_e       state_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] sample_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [EW-1:0]    max_ed_r;
    logic [SUM_W-1:0] sum_ed_r;
    logic             sum_ovf_r;

    logic             accept_s;
    logic             start_go_s;
    logic             last_s;
    logic             v1_s;
    logic             v2_s;
    logic [EW-1:0]    ed_s;
    logic [ACC_W:0]   sum_nxt_s;
    logic             ovf_hit_s;
`ifdef APPROX_ERR_BIAS_EN
    logic signed [EW-1:0]    diff_s;
    logic signed [SUM_W-1:0] bias_r;
    logic [ACC_W:0]          bias_nxt_s;
`endif

    err_dist_calc #(
        .W (W)
    ) u_err_dist_calc (
        .clk  (clk),
        .rst  (rst),
        .load (accept_s),
        .x    (X),
        .y    (Y),
        .p    (P),
        .v1   (v1_s),
        .v2   (v2_s),
`ifdef APPROX_ERR_BIAS_EN
        .diff (diff_s),
`endif
        .ed   (ed_s)
    );

    // Handshake, start qualification and next accumulator values.
    always_comb begin
        accept_s   = in_valid & in_ready_r;
        start_go_s = start & ((state_r == IDLE) | (state_r == DONE));
        last_s     = accept_s & (sample_cnt_r == CNT_W'(N_SAMPLES - 1));
        sum_nxt_s  = sat_add(ACC_W'(sum_ed_r), ACC_W'(ed_s), SUM_W);
        // Bits above SUM_W stay zero after clamping; folding them in keeps the check total.
        ovf_hit_s  = sum_nxt_s[ACC_W] | (|sum_nxt_s[ACC_W-1:SUM_W]);
`ifdef APPROX_ERR_BIAS_EN
        bias_nxt_s = sat_add_signed(ACC_W'(bias_r), ACC_W'(diff_s), SUM_W);
        ovf_hit_s  = ovf_hit_s | bias_nxt_s[ACC_W];
`endif
    end

    // Run control FSM with registered in_ready/busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_go_s) begin
                        state_r    <= RUN;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        state_r    <= DRAIN;
                        in_ready_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Last sample has left stage 1; its stats land on this same edge.
                    if (!v1_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    // Statistics: cleared on an honoured start, sample count on accept, the rest two edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
            max_ed_r     <= {EW{1'b0}};
            sum_ed_r     <= {SUM_W{1'b0}};
            sum_ovf_r    <= 1'b0;
`ifdef APPROX_ERR_BIAS_EN
            bias_r       <= {SUM_W{1'b0}};
`endif
        end else if (start_go_s) begin
            sample_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
            max_ed_r     <= {EW{1'b0}};
            sum_ed_r     <= {SUM_W{1'b0}};
            sum_ovf_r    <= 1'b0;
`ifdef APPROX_ERR_BIAS_EN
            bias_r       <= {SUM_W{1'b0}};
`endif
        end else begin
            if (accept_s) begin
                sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            end
            if (v2_s) begin
                if (|ed_s) begin
                    err_cnt_r <= err_cnt_r + CNT_W'(1);
                end
                if (ed_s > max_ed_r) begin
                    max_ed_r <= ed_s;
                end
                sum_ed_r <= sum_nxt_s[SUM_W-1:0];
                if (ovf_hit_s) begin
                    sum_ovf_r <= 1'b1;
                end
`ifdef APPROX_ERR_BIAS_EN
                bias_r <= bias_nxt_s[SUM_W-1:0];
`endif
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign sample_cnt = sample_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign max_ed     = max_ed_r;
    assign sum_ed     = sum_ed_r;
    assign sum_ovf    = sum_ovf_r;
`ifdef APPROX_ERR_BIAS_EN
    assign bias       = bias_r;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench: two monitors share stimulus, one with N_SAMPLES=4 and a
// 17-bit sum (saturation), one with N_SAMPLES=1 and a 32-bit sum. Expected run
// results are queued when a run is driven and compared when done rises.
module tb_approx_mult_err_monitor;

    localparam int W   = 8;
    localparam int NA  = 4;
    localparam int SWA = 17;
    localparam int SWB = 32;
    localparam int CW  = 16;

    typedef struct {
        longint sample_cnt;
        longint err_cnt;
        longint max_ed;
        longint sum_ed;
        longint sum_ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_a;
    logic            start_b;
    logic            in_valid;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic [2*W-1:0]  p;

    logic            in_ready_a, busy_a, done_a, sum_ovf_a;
    logic [CW-1:0]   sample_cnt_a, err_cnt_a;
    logic [2*W:0]    max_ed_a;
    logic [SWA-1:0]  sum_ed_a;
    logic            in_ready_b, busy_b, done_b, sum_ovf_b;
    logic [CW-1:0]   sample_cnt_b, err_cnt_b;
    logic [2*W:0]    max_ed_b;
    logic [SWB-1:0]  sum_ed_b;
`ifdef APPROX_ERR_BIAS_EN
    logic [SWA-1:0]  bias_a;
    logic [SWB-1:0]  bias_b;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   b_seen      = 1'b0;
    int   b_lat       = -1;
    int   sx [NA];
    int   sy [NA];
    int   sp [NA];
    exp_t q_a [$];
    exp_t q_b [$];

    always #5 clk = ~clk;

    approx_mult_err_monitor #(.W(W), .N_SAMPLES(NA), .CNT_W(CW), .SUM_W(SWA)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .X(x), .Y(y), .P(p), .busy(busy_a), .done(done_a), .sample_cnt(sample_cnt_a),
        .err_cnt(err_cnt_a), .max_ed(max_ed_a), .sum_ed(sum_ed_a),
`ifdef APPROX_ERR_BIAS_EN
        .bias(bias_a),
`endif
        .sum_ovf(sum_ovf_a));

    approx_mult_err_monitor #(.W(W), .N_SAMPLES(1), .CNT_W(CW), .SUM_W(SWB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .X(x), .Y(y), .P(p), .busy(busy_b), .done(done_b), .sample_cnt(sample_cnt_b),
        .err_cnt(err_cnt_b), .max_ed(max_ed_b), .sum_ed(sum_ed_b),
`ifdef APPROX_ERR_BIAS_EN
        .bias(bias_b),
`endif
        .sum_ovf(sum_ovf_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done_b && !b_seen) begin
            b_seen = 1'b1;
            b_lat  = cyc;
        end
    endtask

    task automatic drive(input int i);
        x = sx[i][W-1:0];
        y = sy[i][W-1:0];
        p = sp[i][2*W-1:0];
    endtask

    function automatic exp_t model(input int n, input int sw);
        exp_t   e;
        longint ex, d, ed, lim;
        e   = '{default: 0};
        lim = (longint'(1) << sw) - 1;
        for (int i = 0; i < n; i++) begin
            ex = longint'(sx[i]) * longint'(sy[i]);
            d  = ex - longint'(sp[i]);
            ed = (d < 0) ? -d : d;
            e.sample_cnt++;
            if (ed != 0) e.err_cnt++;
            if (ed > e.max_ed) e.max_ed = ed;
            e.sum_ed += ed;
            if (e.sum_ed > lim) begin
                e.sum_ed  = lim;
                e.sum_ovf = 1;
            end
        end
        return e;
    endfunction

    task automatic set_vec(input int i, input int vx, input int vy, input int vp);
        sx[i] = vx;
        sy[i] = vy;
        sp[i] = vp;
    endtask

    task automatic set_random();
        for (int i = 0; i < NA; i++) begin
            sx[i] = int'($urandom_range(0, 255)) - 128;
            sy[i] = int'($urandom_range(0, 255)) - 128;
            sp[i] = sx[i] * sy[i] + int'($urandom_range(0, 64)) - 32;
        end
    endtask

    // Full run: queue expectations, feed NA triples back to back, compare at done.
    task automatic run_vectors(input bit mid_start);
        int   i, t0, guard;
        logic rdy;
        exp_t ea, eb;
        q_a.push_back(model(NA, SWA));
        q_b.push_back(model(1, SWB));
        start_a = 1'b1;
        start_b = 1'b1;
        b_seen  = 1'b0;
        b_lat   = -1;
        tick();
        t0      = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
        check("in_ready_after_start", in_ready_a, 64'd1);
        check("busy_after_start", busy_a, 64'd1);
        i        = 0;
        guard    = 0;
        in_valid = 1'b1;
        drive(0);
        while (i < NA && guard < 50) begin
            rdy = in_ready_a;
            if (mid_start && i == 2) start_a = 1'b1;
            tick();
            guard++;
            start_a = 1'b0;
            if (rdy) begin
                i++;
                if (i < NA) drive(i);
            end
        end
        in_valid = 1'b0;
        check("accept_cycles", 64'(cyc - t0), 64'(NA));
        check("in_ready_drop", in_ready_a, 64'd0);
        check("busy_in_drain", busy_a, 64'd1);
        guard = 0;
        while (!done_a && guard < 20) begin
            tick();
            guard++;
        end
        check("done_a_latency", 64'(cyc - t0), 64'(NA + 2));
        check("done_a", done_a, 64'd1);
        check("busy_a_at_done", busy_a, 64'd0);
        check("done_b_latency", 64'(b_lat - t0), 64'd3);
        check("done_b", done_b, 64'd1);
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("a_sample_cnt", sample_cnt_a, 64'(ea.sample_cnt));
        check("a_err_cnt",    err_cnt_a,    64'(ea.err_cnt));
        check("a_max_ed",     max_ed_a,     64'(ea.max_ed));
        check("a_sum_ed",     sum_ed_a,     64'(ea.sum_ed));
        check("a_sum_ovf",    sum_ovf_a,    64'(ea.sum_ovf));
        check("b_sample_cnt", sample_cnt_b, 64'(eb.sample_cnt));
        check("b_err_cnt",    err_cnt_b,    64'(eb.err_cnt));
        check("b_max_ed",     max_ed_b,     64'(eb.max_ed));
        check("b_sum_ed",     sum_ed_b,     64'(eb.sum_ed));
        check("b_sum_ovf",    sum_ovf_b,    64'(eb.sum_ovf));
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
        x        = 8'd0;
        y        = 8'd0;
        p        = 16'd0;
        tick();
        tick();
        check("rst_sample_cnt", sample_cnt_a, 64'd0);
        check("rst_busy", busy_a, 64'd0);
        check("rst_done", done_a, 64'd0);
        check("rst_in_ready", in_ready_a, 64'd0);
        check("rst_sum_ed", sum_ed_a, 64'd0);
        check("rst_max_ed", max_ed_a, 64'd0);
        rst = 1'b0;
        tick();

        // Exact match on the first triple, ED=3, ED=32768 and a clean one.
        set_vec(0, 105, -107, -11235);
        set_vec(1, 105, -107, -11232);
        set_vec(2, -128, -128, -16384);
        set_vec(3, 7, 9, 63);
        run_vectors(1'b0);

        // ED=3 first for the single-sample monitor; start pulsed mid-run on A.
        set_random();
        set_vec(0, 105, -107, -11232);
        run_vectors(1'b1);

        // Maximum ED every sample: 17-bit sum saturates, 32-bit does not.
        for (int i = 0; i < NA; i++) set_vec(i, -128, -128, -32768);
        run_vectors(1'b0);

        // Reset while in RUN after two accepts.
        set_random();
        start_a = 1'b1;
        start_b = 1'b1;
        tick();
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b1;
        drive(0);
        tick();
        drive(1);
        tick();
        check("pre_rst_cnt", sample_cnt_a, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_run_cnt", sample_cnt_a, 64'd0);
        check("rst_run_busy", busy_a, 64'd0);
        check("rst_run_in_ready", in_ready_a, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_ignores_valid", sample_cnt_a, 64'd0);
        check("idle_in_ready", in_ready_a, 64'd0);
        in_valid = 1'b0;

        set_random();
        run_vectors(1'b0);

        // In DONE, valid triples are ignored and results hold.
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check("done_ignores_valid", sample_cnt_a, 64'(NA));
        check("done_holds", done_a, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
